// File: rtl/reply_encoder.sv
// reply_encoder: gathers a run of bytes from one source and sends it to the UART TX
// as a framed reply packet: PREFIX, dest, len, payload, crc.
module reply_encoder #(
  parameter int unsigned N_SRC    = 8,
  parameter logic [7:0]  PREFIX   = 8'hAA,
  parameter int unsigned MAX_LEN  = 255,
  parameter int unsigned IDLE_CYC = 1000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       in_data,
  input  logic [N_SRC-1:0] in_valid_bus,
  output logic             in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(IDLE_CYC);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, COLLECT, S_PREFIX, S_DEST, S_LEN, S_DATA, S_CRC
  } state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]       buf_q [MAX_LEN];

  logic [SRC_W-1:0] in_idx;
  logic             any_valid;
  logic             accept;
  logic             xfer;
  logic             wr_en;
  logic             close;
  logic [LEN_W-1:0] len_inc;
  logic [7:0]       rd_byte;

  // Lowest set bit wins; extra bits of a multi-hot strobe are ignored.
  always_comb begin
    in_idx    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (in_valid_bus[i] && !any_valid) begin
        in_idx    = SRC_W'(i);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    case (state_q)
      IDLE:    in_ready = 1'b1;
      COLLECT: in_ready = (!any_valid || (in_idx == src_q)) && (len_q < LEN_MAX);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = any_valid && in_ready;
  assign xfer     = tx_valid_q && tx_ready;
  assign len_inc  = len_q + LEN_W'(1);
  assign rd_byte  = buf_q[rd_ptr_q[IDX_W-1:0]];
  assign busy     = (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    crc_d      = crc_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    idle_cnt_d = idle_cnt_q;
    wr_en      = 1'b0;
    close      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d      = in_idx;
          wr_en      = 1'b1;
          len_d      = len_inc;
          crc_d      = in_data;
          idle_cnt_d = '0;
          if (len_inc == LEN_MAX) close = 1'b1;
          else                    state_d = COLLECT;
        end
      end
      COLLECT: begin
        // A byte that fills the buffer closes on the same cycle it is taken.
        if (accept) begin
          wr_en      = 1'b1;
          len_d      = len_inc;
          crc_d      = crc_q + in_data;
          idle_cnt_d = '0;
          close      = (len_inc == LEN_MAX);
        end else if (any_valid || (idle_cnt_q == CNT_LAST)) begin
          close = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      S_PREFIX: if (xfer) begin
        tx_data_d = 8'(src_q);
        state_d   = S_DEST;
      end
      S_DEST: if (xfer) begin
        tx_data_d = 8'(len_q);
        state_d   = S_LEN;
      end
      S_LEN: if (xfer) begin
        tx_data_d = rd_byte;
        rd_ptr_d  = rd_ptr_q + LEN_W'(1);
        state_d   = S_DATA;
      end
      S_DATA: if (xfer) begin
        if (rd_ptr_q == len_q) begin
          tx_data_d = crc_q;
          state_d   = S_CRC;
        end else begin
          tx_data_d = rd_byte;
          rd_ptr_d  = rd_ptr_q + LEN_W'(1);
        end
      end
      S_CRC: if (xfer) begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
        len_d      = '0;
        crc_d      = '0;
        rd_ptr_d   = '0;
        idle_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (close) begin
      state_d    = S_PREFIX;
      tx_valid_d = 1'b1;
      tx_data_d  = PREFIX;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      crc_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[len_q[IDX_W-1:0]] <= in_data;
  end

endmodule

// File: doc/reply_encoder.md
# reply_encoder

Packs byte streams returned by peripheral stages into framed reply packets (PREFIX, dest, len, data, crc) for the UART transmitter. It sits downstream of the per-destination peripheral handlers and upstream of the UART TX. It takes bytes tagged with a one-hot source bus, the same format as the command decoder's `valid_bus`. The frame format mirrors the command path, so the host parses replies with the same parser.

## Interface
Parameters:
- `N_SRC`, 8, number of sources; width of `in_valid_bus`.
- `PREFIX`, 8'hAA, frame start byte.
- `MAX_LEN`, 255, maximum payload bytes per packet (1..255).
- `IDLE_CYC`, 1000, idle cycles in COLLECT that close the packet (≥2).

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  8  payload byte.
- `in_valid_bus`  in  N_SRC  one-hot byte strobe; the set bit index is the source.
- `in_ready`  out  1  combinational; the byte is accepted when `|in_valid_bus & in_ready`.
- `tx_data`  out  8  registered byte to the UART TX.
- `tx_valid`  out  1  registered; `tx_data` is valid.
- `tx_ready`  in  1  UART TX accepts; the byte transfers when `tx_valid & tx_ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - COLLECT
  - S_PREFIX
  - S_DEST
  - S_LEN
  - S_DATA
  - S_CRC
- Source index is the lowest set bit of `in_valid_bus`. Multi-hot input is attributed to that index, with no error.
- IDLE:
  - `in_ready`=1.
  - On an accepted byte: latch `src`, write the byte to the buffer, set len=1, set crc=byte, clear the idle counter, go to COLLECT.
- COLLECT:
  - `in_ready` = (`in_valid_bus`==0 or the source matches `src`) and len<MAX_LEN.
  - Accepted byte: append it, len+1, crc = crc+byte mod 256, clear the idle counter.
  - Otherwise the idle counter increments.
- Close conditions, checked in COLLECT; the next state is S_PREFIX.
  - len==MAX_LEN.
  - A byte is presented from a different source. It is not accepted and must be held by the producer.
  - The idle counter reaches IDLE_CYC-1.
- Send phase:
  - `in_ready`=0.
  - Emit PREFIX, then `src` (8-bit, zero-extended), then len, then len buffer bytes in arrival order, then crc.
  - Each state advances on a transfer. S_DATA stays until all len bytes have transferred.
  - S_CRC transfer: go to IDLE, and reset len, crc and the buffer pointers.
- Buffer: MAX_LEN bytes. Read order equals write order. No overflow is possible because `in_ready` gates at MAX_LEN.
- No zero-length packets are ever emitted.
- CRC is the 8-bit wrapping sum of payload bytes only, the same as the command path.

## Timing
- Reset values:
  - state IDLE
  - `tx_valid`=0
  - `tx_data`=0
  - `busy`=0
  - `in_ready`=1
  - len, crc, pointers and idle counter = 0
- Asserting reset mid-packet discards the packet. `tx_valid` drops asynchronously.
- Byte accepted in IDLE at cycle t: `busy`=1 at t+1.
- Close condition true at cycle t: `tx_valid`=1 with `tx_data`=PREFIX at t+1.
- `tx_data` and `tx_valid` stay stable while `tx_valid & !tx_ready`. The next byte is presented the cycle after a transfer.
- With `tx_ready` held high, a packet occupies exactly len+4 consecutive `tx_valid` cycles with no bubbles.
- Last CRC transfer at cycle t: IDLE, `tx_valid`=0 and `in_ready`=1 at t+1.
- Idle timeout with `IDLE_CYC`=N: with no input after the last accepted byte at cycle t, `tx_valid` rises at t+N+1.
- MAX_LEN close: the last byte accepted at t gives `in_ready`=0 from t+1. PREFIX appears at t+1 with `tx_valid` high.
- Simultaneous events:
  - If a different-source byte arrives on the same cycle the idle counter hits the limit, the packet closes once; the byte is held.
  - A byte presented during the send phase is held. It is accepted in IDLE the cycle after the CRC transfer.

## Test plan
- Idle-timeout close: source 2 sends 01 02 03, then nothing, `tx_ready`=1 → TX sequence AA 02 03 01 02 03 06, 7 consecutive cycles, then `busy`=0.
- Source switch: source 1 sends 10 20, then source 4 presents 05 immediately → `in_ready`=0 on 05. TX is AA 01 02 10 20 30. Next packet is AA 04 01 05 05.
- MAX_LEN with `MAX_LEN`=4: source 0 streams 8 bytes FF → first packet AA 00 04 FF FF FF FF FC, second packet the same. CRC wraps: 4×FF = FC.
- Backpressure: toggle `tx_ready` randomly, 50%, during an 8-byte packet → byte order intact and `tx_data` stable while stalled. Exactly 12 transfers.
- Reset mid S_DATA: assert `n_rst`=0 after 2 data bytes have transferred → `tx_valid`=0 immediately and `in_ready`=1 after release. A new packet frames correctly.
- Multi-hot: `in_valid_bus`=8'b0000_1100 with byte 7E, then idle → AA 02 01 7E 7E.
